// File: rtl/vec_window_pkg.sv
// Shared constants and helpers for the wake-word sliding-window stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vec_window_pkg;

    localparam int BW         = 8;                    // bits per signed feature element
    localparam int VECTOR_LEN = 13;                   // elements per feature vector
    localparam int KERNEL_LEN = 3;                    // vectors per window, must be >= 2
    localparam int VECTOR_BW  = VECTOR_LEN * BW;      // one packed vector
    localparam int WINDOW_BW  = KERNEL_LEN * VECTOR_BW;
    localparam int CNT_W      = $clog2(KERNEL_LEN + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX  = cnt_t'(KERNEL_LEN);
    localparam cnt_t CNT_FULL = cnt_t'(KERNEL_LEN - 1);

    // Fill count after one more accepted vector, saturating at KERNEL_LEN.
    function automatic cnt_t cnt_next(input cnt_t c);
        if (c >= CNT_MAX) begin
            return CNT_MAX;
        end
        return c + cnt_t'(1);
    endfunction

    // True when the vector being accepted completes a window (cnt+1 >= KERNEL_LEN).
    function automatic logic window_full(input cnt_t c);
        return (c >= CNT_FULL);
    endfunction

endpackage

// File: rtl/vec_window_if.sv
// Valid/ready/last stream bundle of configurable data width.
// Latency: n/a (wiring only).
// Backpressure: ready travels slave -> master; master drives data/valid/last.
interface vec_window_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          valid;
    logic          last;
    logic          ready;

    modport master (output data, output valid, output last, input  ready);
    modport slave  (input  data, input  valid, input  last, output ready);
endinterface

// File: rtl/vec_shift_reg.sv
// DEPTH x WIDTH shift register; new word enters the top slot, slot 0 holds the oldest.
// Latency: 1 cycle from en to q; q_shift is the combinational next value.
// Backpressure: none; en shifts unconditionally, clr (sync) wins over en.
// Ports: clk, rst_n (sync, active-low), clr, en, din[WIDTH], q[DEPTH*WIDTH], q_shift[DEPTH*WIDTH]
module vec_shift_reg #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 104
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic [WIDTH-1:0]       din,
    output logic [DEPTH*WIDTH-1:0] q,
    output logic [DEPTH*WIDTH-1:0] q_shift
);

    // Drop slot 0, move every slot down one, new word lands in slot DEPTH-1.
    assign q_shift = {din, q[DEPTH*WIDTH-1:WIDTH]};

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            q <= '0;
        end else if (en) begin
            q <= q_shift;
        end
    end

endmodule

// File: rtl/vec_window.sv
// Sliding window of KERNEL_LEN padded feature vectors; one window out per accepted vector, never across frames.
// Latency: 1 cycle from the accepting edge to valid_o/data_o/last_o/short_frame_o.
// Backpressure: none; every valid input is accepted, ready_i is only registered onto ready_o.
// Ports: clk_i, rst_n_i (sync, active-low), src (slave: data_i/valid_i/last_i/ready_o),
//        dst (master: data_o/valid_o/last_o/ready_i), short_frame_o
module vec_window
    import vec_window_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    vec_window_if.slave  src,
    vec_window_if.master dst,
    output logic         short_frame_o
);

    logic [WINDOW_BW-1:0] win_q;
    logic [WINDOW_BW-1:0] win_shift;
    cnt_t                 cnt;
    logic                 accept;
    logic                 frame_end;
    logic                 full;

    assign accept    = src.valid;
    assign frame_end = src.valid & src.last;
    assign full      = window_full(cnt);

    // Slots are wiped on the accepting edge of last_i, so the following
    // cycle can already start a fresh frame without any stale vectors.
    vec_shift_reg #(
        .DEPTH (KERNEL_LEN),
        .WIDTH (VECTOR_BW)
    ) u_slots (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .clr     (frame_end),
        .en      (accept),
        .din     (src.data),
        .q       (win_q),
        .q_shift (win_shift)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt           <= '0;
            dst.valid     <= 1'b0;
            dst.last      <= 1'b0;
            dst.data      <= '0;
            short_frame_o <= 1'b0;
            src.ready     <= 1'b0;
        end else begin
            dst.valid     <= accept & full;
            dst.last      <= frame_end & full;
            short_frame_o <= frame_end & ~full;
            // Idle cycles present an all-zero bus rather than a stale window.
            dst.data      <= (accept & full) ? win_shift : '0;
            src.ready     <= dst.ready;

            if (frame_end) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt_next(cnt);
            end
        end
    end

endmodule

// File: tb/tb_vec_window.sv
// Directed bench for vec_window: window order, gaps, short frames, frame boundaries, reset, sign, ready pass-through.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_vec_window;
    import vec_window_pkg::*;

    logic clk;
    logic rst_n;
    logic short_frame;
    int   tests;
    int   fails;

    vec_window_if #(.DW(VECTOR_BW)) src ();
    vec_window_if #(.DW(WINDOW_BW)) dst ();

    vec_window dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .src           (src),
        .dst           (dst),
        .short_frame_o (short_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [VECTOR_BW-1:0] vec(input logic [7:0] n);
        return {VECTOR_LEN{n}};
    endfunction

    // Window whose newest vector is Vn: {Vn, Vn-1, Vn-2}, slice 0 oldest.
    function automatic logic [WINDOW_BW-1:0] win(input logic [7:0] n);
        return {vec(n), vec(n - 8'd1), vec(n - 8'd2)};
    endfunction

    // Present one input cycle, then step to just after the accepting edge.
    task automatic drive(input logic v, input logic [7:0] n, input logic l);
        src.valid = v;
        src.data  = v ? vec(n) : '0;
        src.last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        dst.ready = 1'b1;
        drive(1'b1, 8'd5, 1'b1);
        drive(1'b1, 8'd6, 1'b1);
        tests++; if (dst.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", dst.valid); end
        tests++; if (dst.last !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", dst.last); end
        tests++; if (dst.data !== '0) begin fails++; $display("FAIL reset_data got=%h exp=0", dst.data); end
        tests++; if (short_frame !== 1'b0) begin fails++; $display("FAIL reset_short got=%b exp=0", short_frame); end
        tests++; if (src.ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", src.ready); end
        rst_n = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        tests++; if (src.ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready got=%b exp=1", src.ready); end
        tests++; if (dst.valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid got=%b exp=0", dst.valid); end
    endtask

    task automatic test_back_to_back();
        logic ev, el;
        logic [WINDOW_BW-1:0] ed;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), i == 4);
            ev = (i >= 2);
            el = (i == 4);
            ed = ev ? win(8'(i)) : '0;
            tests++;
            if (dst.valid !== ev || dst.last !== el || dst.data !== ed || short_frame !== 1'b0) begin
                fails++;
                $display("FAIL b2b[%0d] valid=%b last=%b short=%b exp valid=%b last=%b data_ok=%b",
                         i, dst.valid, dst.last, short_frame, ev, el, dst.data === ed);
            end
        end
        drive(1'b0, 8'd0, 1'b0);
        tests++;
        if (dst.valid !== 1'b0 || dst.data !== '0) begin
            fails++; $display("FAIL b2b_idle valid=%b data=%h exp valid=0 data=0", dst.valid, dst.data);
        end
    endtask

    task automatic test_gap();
        logic vin [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int   id  [7] = '{0, 1, 0, 0, 2, 3, 4};
        logic evs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic el;
        logic [WINDOW_BW-1:0] ed;
        for (int i = 0; i < 7; i++) begin
            drive(vin[i], 8'(id[i]), i == 6);
            el = (i == 6);
            ed = evs[i] ? win(8'(id[i])) : '0;
            tests++;
            if (dst.valid !== evs[i] || dst.last !== el || dst.data !== ed) begin
                fails++;
                $display("FAIL gap[%0d] valid=%b last=%b exp valid=%b last=%b data_ok=%b",
                         i, dst.valid, dst.last, evs[i], el, dst.data === ed);
            end
        end
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_short_frame();
        drive(1'b1, 8'd7, 1'b0);
        tests++;
        if (dst.valid !== 1'b0 || short_frame !== 1'b0) begin
            fails++; $display("FAIL short_v7 valid=%b short=%b exp 0 0", dst.valid, short_frame);
        end
        drive(1'b1, 8'd8, 1'b1);
        tests++;
        if (dst.valid !== 1'b0 || dst.last !== 1'b0 || short_frame !== 1'b1) begin
            fails++; $display("FAIL short_v8 valid=%b last=%b short=%b exp 0 0 1", dst.valid, dst.last, short_frame);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i), i == 3);
            tests++;
            if (i < 3) begin
                if (dst.valid !== 1'b0 || short_frame !== 1'b0) begin
                    fails++; $display("FAIL short_next[%0d] valid=%b short=%b exp 0 0", i, dst.valid, short_frame);
                end
            end else if (dst.valid !== 1'b1 || dst.last !== 1'b1 || dst.data !== win(8'd3) || short_frame !== 1'b0) begin
                fails++;
                $display("FAIL short_next_win valid=%b last=%b short=%b data=%h exp 1 1 0 %h",
                         dst.valid, dst.last, short_frame, dst.data, win(8'd3));
            end
        end
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_frame_boundary();
        int   id  [7] = '{0, 1, 2, 3, 9, 10, 11};
        logic lin [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic evs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [WINDOW_BW-1:0] ed;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(id[i]), lin[i]);
            ed = evs[i] ? win(8'(id[i])) : '0;
            tests++;
            if (dst.valid !== evs[i] || dst.last !== lin[i] || dst.data !== ed) begin
                fails++;
                $display("FAIL bound[%0d] valid=%b last=%b data=%h exp valid=%b last=%b data=%h",
                         i, dst.valid, dst.last, dst.data, evs[i], lin[i], ed);
            end
        end
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 8'd0, 1'b0);
        drive(1'b1, 8'd1, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        tests++;
        if (dst.valid !== 1'b0 || dst.last !== 1'b0 || dst.data !== '0 || short_frame !== 1'b0) begin
            fails++; $display("FAIL midrst_out valid=%b last=%b short=%b data=%h exp all 0",
                              dst.valid, dst.last, short_frame, dst.data);
        end
        for (int i = 5; i <= 7; i++) begin
            drive(1'b1, 8'(i), i == 7);
            tests++;
            if (i < 7) begin
                if (dst.valid !== 1'b0) begin
                    fails++; $display("FAIL midrst_fill[%0d] valid=%b exp 0", i, dst.valid);
                end
            end else if (dst.valid !== 1'b1 || dst.last !== 1'b1 || dst.data !== win(8'd7)) begin
                fails++; $display("FAIL midrst_win valid=%b last=%b data=%h exp 1 1 %h",
                                  dst.valid, dst.last, dst.data, win(8'd7));
            end
        end
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_sign_ready();
        logic [VECTOR_BW-1:0] p [3];
        logic rdy [3] = '{1'b0, 1'b1, 1'b0};
        logic [WINDOW_BW-1:0] ed;
        p[0] = {VECTOR_LEN{8'h80}};
        p[1] = {VECTOR_LEN{8'hFF}};
        for (int e = 0; e < VECTOR_LEN; e++) begin
            p[2][e*BW +: BW] = (e % 2 == 0) ? 8'h80 : 8'hFF;
        end
        ed = {p[2], p[1], p[0]};
        for (int i = 0; i < 3; i++) begin
            dst.ready = rdy[i];
            src.valid = 1'b1;
            src.data  = p[i];
            src.last  = (i == 2);
            @(posedge clk);
            #1;
            tests++;
            if (src.ready !== rdy[i]) begin
                fails++; $display("FAIL ready[%0d] got=%b exp=%b", i, src.ready, rdy[i]);
            end
        end
        tests++;
        if (dst.valid !== 1'b1 || dst.last !== 1'b1 || dst.data !== ed) begin
            fails++; $display("FAIL sign_win valid=%b last=%b data=%h exp 1 1 %h", dst.valid, dst.last, dst.data, ed);
        end
        dst.ready = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        tests++;
        if (src.ready !== 1'b1 || dst.valid !== 1'b0) begin
            fails++; $display("FAIL ready_idle ready=%b valid=%b exp 1 0", src.ready, dst.valid);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        src.valid = 1'b0;
        src.data  = '0;
        src.last  = 1'b0;
        dst.ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_gap();
        test_short_frame();
        test_frame_boundary();
        test_mid_reset();
        test_sign_ready();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
